fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the 8-bit sync FIFO between N_REQ producers.
- Grants one producer at a time and lets the owner write up to MAX_BURST consecutive words.
- Drives the FIFO's wr_en/wdata and honours the FIFO's full flag.
- Sits between the producer blocks and the FIFO; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the 8-bit sync FIFO, with bursts of up to MAX_BURST words.
// Optional full-stall counter enabled by defining FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
    parameter int N_REQ = 4,
    parameter int DATA_W = 8,
    parameter int MAX_BURST = 4,
    localparam int OWN_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] wdata_in,
    output logic [N_REQ-1:0]        ack,
    input  logic                    full,
    output logic                    wr_en,
    output logic [DATA_W-1:0]       wdata,
    output logic [OWN_W-1:0]        owner,
    output logic                    busy,
    output logic [15:0]             stall_cnt
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [OWN_W-1:0] rr_ptr;
    logic [7:0]       cnt;
    logic             found;
    logic [OWN_W-1:0] win;

    function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] i);
        if (i == OWN_W'(N_REQ - 1))
            return '0;
        return i + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping at N_REQ-1
    always_comb begin
        int               idx;
        logic [OWN_W-1:0] sel;
        found = 1'b0;
        win   = rr_ptr;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            sel = OWN_W'(idx);
            if (!found && req[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
    end

    // Zero-latency grant: never while full, never in reset
    always_comb begin
        ack = '0;
        if (!rst && !full) begin
            if (state == IDLE) begin
                if (found)
                    ack[win] = 1'b1;
            end else if (req[owner]) begin
                ack[owner] = 1'b1;
            end
        end
    end

    // Steer the acked producer's word onto the FIFO port
    always_comb begin
        wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ack[i])
                wdata = wdata_in[i*DATA_W +: DATA_W];
        end
    end

    assign wr_en = |ack;
    assign busy  = (state == BURST);

    // Ownership FSM: grant in IDLE, hold the lock through BURST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found && !full) begin
                        owner <= win;
                        if (MAX_BURST == 1) begin
                            rr_ptr <= next_idx(win);
                        end else begin
                            state <= BURST;
                            cnt   <= 8'd1;
                        end
                    end
                end
                BURST: begin
                    if (req[owner]) begin
                        if (!full) begin
                            if (cnt + 8'd1 == 8'(MAX_BURST)) begin
                                state  <= IDLE;
                                rr_ptr <= next_idx(owner);
                                cnt    <= '0;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end else begin
                        state  <= IDLE;
                        rr_ptr <= next_idx(owner);
                        cnt    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count cycles where someone wants to write but the FIFO is full
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (full && (|req) && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes predicted outputs,
// a negedge monitor pops and compares them.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] wdata_in;
    logic [N-1:0]  ack;
    logic          full;
    logic          wr_en;
    logic [DW-1:0] wdata;
    logic [1:0]    owner;
    logic          busy;
    logic [15:0]   stall_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata_in(wdata_in),
        .ack(ack), .full(full), .wr_en(wr_en), .wdata(wdata),
        .owner(owner), .busy(busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] wdata;
        logic          busy;
        logic [1:0]    owner;
        logic [15:0]   stall;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference: who holds the port, how many words it has used, where the search starts
    bit m_locked = 0;
    int m_own = 0;
    int m_used = 0;
    int m_ptr = 0;
    int m_stall = 0;
    logic [N-1:0] last_ack = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input logic [N-1:0] rq, input bit f, input bit fixed);
        exp_t e;
        int w;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fixed)
                wdata_in[i*DW +: DW] = 8'h10 + 8'(i);
            else if (last_ack[i] || !rq[i])
                wdata_in[i*DW +: DW] = 8'($urandom);
        end
        rst  = r;
        req  = rq;
        full = f;
        e.ack   = '0;
        e.wdata = '0;
        e.busy  = m_locked;
        e.owner = 2'(m_own);
        e.stall = 16'(m_stall);
        if (r) begin
            m_locked = 0; m_own = 0; m_used = 0; m_ptr = 0; m_stall = 0;
            e.busy = 0; e.owner = 0; e.stall = 0;
            last_ack = '0;
            q.push_back(e);
            return;
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        if (f && (|rq) && m_stall < 65535)
            m_stall++;
`endif
        if (!m_locked) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && rq[(m_ptr + k) % N])
                    w = (m_ptr + k) % N;
            if (w >= 0 && !f) begin
                e.ack[w] = 1'b1;
                m_own = w;
                if (MB == 1) begin
                    m_ptr = (w + 1) % N;
                end else begin
                    m_locked = 1;
                    m_used = 1;
                end
            end
        end else if (!rq[m_own]) begin
            m_locked = 0;
            m_used = 0;
            m_ptr = (m_own + 1) % N;
        end else if (!f) begin
            e.ack[m_own] = 1'b1;
            m_used++;
            if (m_used == MB) begin
                m_locked = 0;
                m_used = 0;
                m_ptr = (m_own + 1) % N;
            end
        end
        for (int i = 0; i < N; i++)
            if (e.ack[i])
                e.wdata = wdata_in[i*DW +: DW];
        last_ack = e.ack;
        q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ack", 32'(ack), 32'(e.ack));
                check("wr_en", 32'(wr_en), 32'(|e.ack));
                check("wdata", 32'(wdata), 32'(e.wdata));
                check("busy", 32'(busy), 32'(e.busy));
                check("owner", 32'(owner), 32'(e.owner));
                check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        rst = 1'b1;
        req = '0;
        full = 1'b0;
        wdata_in = '0;
        repeat (3) step(1, '0, 0, 0);

        repeat (20) step(0, 4'b1111, 0, 1);

        step(1, '0, 0, 0);
        repeat (6) step(0, 4'b0010, 0, 0);
        repeat (2) step(0, 4'b0000, 0, 0);

        step(1, '0, 0, 0);
        repeat (2) step(0, 4'b1000, 0, 0);
        repeat (3) step(0, 4'b1000, 1, 0);
        repeat (3) step(0, 4'b1000, 0, 0);
        step(0, 4'b0000, 0, 0);

        step(1, '0, 0, 0);
        step(0, 4'b0101, 0, 0);
        step(0, 4'b0100, 0, 0);
        repeat (2) step(0, 4'b0100, 0, 0);
        step(0, 4'b0000, 0, 0);

        step(1, '0, 0, 0);
        repeat (10) step(0, 4'b0001, 1, 0);
        repeat (2) step(0, 4'b0000, 0, 0);

        step(1, '0, 0, 0);
        repeat (4) step(0, 4'b0100, 0, 0);
        step(0, 4'b0110, 0, 0);
        step(0, 4'b0110, 0, 0);
        step(1, 4'b0111, 0, 0);
        repeat (3) step(0, 4'b0111, 0, 0);

        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0)
                    rq[i] = ~rq[i];
            step($urandom_range(0, 199) == 0, rq,
                 $urandom_range(0, 4) == 0, 0);
        end

        repeat (3) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
